multicycle_subtractor: RTL and testbench

- Iterative subtractor that computes operand1_i - operand2_i - borrow_i over several cycles, processing CHUNK_WIDTH bits per cycle.
- The inverse companion of the arithmetic adder blocks in the math library.
- Each cycle's slice is a full_subtractor borrow chain; the borrow is registered between chunks to bound the critical path.
- Valid/ready handshake on both input and output; feeds ALU and datapath consumers that tolerate multi-cycle latency.

---
 rtl/multicycle_subtractor_pkg.sv | 15 +
 rtl/multicycle_subtractor_full_subtractor.sv | 13 +
 rtl/multicycle_subtractor.sv | 143 ++++++++++++++
 tb/tb_multicycle_subtractor.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/multicycle_subtractor_pkg.sv
// Shared types and helpers for the multicycle subtractor.
package sub_pkg;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } sub_state_e;

    // Chunk counter width; never narrower than one bit so a single-chunk build still elaborates.
    function automatic int unsigned cnt_width(input int unsigned num_chunks);
        return (num_chunks > 1) ? $clog2(num_chunks) : 1;
    endfunction

endpackage

// File: rtl/multicycle_subtractor_full_subtractor.sv
// Single-bit full subtractor cell: d = a - b - bin, bout = borrow-out.
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = a ^ b ^ bin;
    assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/multicycle_subtractor.sv
// Iterative subtractor: operand1 - operand2 - borrow_i, CHUNK_WIDTH bits per cycle.
// The borrow is registered between chunks so the critical path is one chunk's ripple.
// Optional macro SUB_OVERFLOW_EN adds overflow_o (signed two's-complement overflow).
module multicycle_subtractor
    import sub_pkg::*;
#(
    parameter int BIT_WIDTH   = 32,
    parameter int CHUNK_WIDTH = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 in_valid_i,
    output logic                 in_ready_o,
    input  logic [BIT_WIDTH-1:0] operand1_i,
    input  logic [BIT_WIDTH-1:0] operand2_i,
    input  logic                 borrow_i,
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output logic [BIT_WIDTH-1:0] diff_o,
    output logic                 borrow_o
`ifdef SUB_OVERFLOW_EN
    ,
    output logic                 overflow_o
`endif
);

    localparam int NUM_CHUNKS = BIT_WIDTH / CHUNK_WIDTH;
    localparam int CNT_W      = cnt_width(NUM_CHUNKS);
    localparam int MSB        = BIT_WIDTH - 1;
    localparam logic [CNT_W-1:0] LAST_CHUNK = CNT_W'(NUM_CHUNKS - 1);

    if (BIT_WIDTH % CHUNK_WIDTH != 0) begin : g_bad_width
        $error("BIT_WIDTH must be a multiple of CHUNK_WIDTH");
    end

    sub_state_e             state_q;
    logic [CNT_W-1:0]       cnt_q;
    logic [BIT_WIDTH-1:0]   a_q;
    logic [BIT_WIDTH-1:0]   b_q;
    logic                   borrow_q;
    logic [BIT_WIDTH-1:0]   diff_q;
    logic                   out_valid_q;
    logic [BIT_WIDTH-1:0]   diff_out_q;
    logic                   borrow_out_q;
`ifdef SUB_OVERFLOW_EN
    logic                   overflow_q;
`endif

    logic [CHUNK_WIDTH-1:0] a_chunk;
    logic [CHUNK_WIDTH-1:0] b_chunk;
    logic [CHUNK_WIDTH-1:0] d_chunk;
    logic [CHUNK_WIDTH:0]   chain;
    logic [BIT_WIDTH-1:0]   diff_next;
    int                     base;

    // Select the current chunk's operand slices and merge its result into the partial difference.
    always_comb begin
        base      = int'(cnt_q) * CHUNK_WIDTH;
        a_chunk   = a_q[base +: CHUNK_WIDTH];
        b_chunk   = b_q[base +: CHUNK_WIDTH];
        diff_next = diff_q;
        diff_next[base +: CHUNK_WIDTH] = d_chunk;
    end

    assign chain[0] = borrow_q;

    for (genvar i = 0; i < CHUNK_WIDTH; i++) begin : g_chain
        full_subtractor u_fs (
            .a   (a_chunk[i]),
            .b   (b_chunk[i]),
            .bin (chain[i]),
            .d   (d_chunk[i]),
            .bout(chain[i+1])
        );
    end

    // Control FSM plus datapath registers; result registers are loaded only on entry to DONE.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            a_q          <= '0;
            b_q          <= '0;
            borrow_q     <= 1'b0;
            diff_q       <= '0;
            out_valid_q  <= 1'b0;
            diff_out_q   <= '0;
            borrow_out_q <= 1'b0;
`ifdef SUB_OVERFLOW_EN
            overflow_q   <= 1'b0;
`endif
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (in_valid_i) begin
                        a_q      <= operand1_i;
                        b_q      <= operand2_i;
                        borrow_q <= borrow_i;
                        diff_q   <= '0;
                        cnt_q    <= '0;
                        state_q  <= BUSY;
                    end
                end
                BUSY: begin
                    diff_q   <= diff_next;
                    borrow_q <= chain[CHUNK_WIDTH];
                    cnt_q    <= cnt_q + CNT_W'(1);
                    if (cnt_q == LAST_CHUNK) begin
                        cnt_q        <= '0;
                        state_q      <= DONE;
                        out_valid_q  <= 1'b1;
                        diff_out_q   <= diff_next;
                        borrow_out_q <= chain[CHUNK_WIDTH];
`ifdef SUB_OVERFLOW_EN
                        overflow_q   <= (a_q[MSB] != b_q[MSB]) && (diff_next[MSB] != a_q[MSB]);
`endif
                    end
                end
                DONE: begin
                    if (out_ready_i) begin
                        state_q      <= IDLE;
                        out_valid_q  <= 1'b0;
                        diff_out_q   <= '0;
                        borrow_out_q <= 1'b0;
`ifdef SUB_OVERFLOW_EN
                        overflow_q   <= 1'b0;
`endif
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready_o  = (state_q == IDLE);
    assign out_valid_o = out_valid_q;
    assign diff_o      = diff_out_q;
    assign borrow_o    = borrow_out_q;
`ifdef SUB_OVERFLOW_EN
    assign overflow_o  = overflow_q;
`endif

endmodule

// File: tb/tb_multicycle_subtractor.sv
// Randomized self-checking bench for multicycle_subtractor against an arithmetic reference model.
module tb_multicycle_subtractor;

    localparam int BW = 32;
    localparam int CW = 8;
    localparam int NC = BW / CW;

    logic          clk_i = 1'b0;
    logic          rst_ni = 1'b0;
    logic          in_valid_i = 1'b0;
    logic          in_ready_o;
    logic [BW-1:0] operand1_i = '0;
    logic [BW-1:0] operand2_i = '0;
    logic          borrow_i = 1'b0;
    logic          out_valid_o;
    logic          out_ready_i = 1'b0;
    logic [BW-1:0] diff_o;
    logic          borrow_o;
`ifdef SUB_OVERFLOW_EN
    logic          overflow_o;
`endif

    int n_cmp = 0;
    int n_err = 0;

    multicycle_subtractor #(
        .BIT_WIDTH  (BW),
        .CHUNK_WIDTH(CW)
    ) dut (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .in_valid_i (in_valid_i),
        .in_ready_o (in_ready_o),
        .operand1_i (operand1_i),
        .operand2_i (operand2_i),
        .borrow_i   (borrow_i),
        .out_valid_o(out_valid_o),
        .out_ready_i(out_ready_i),
        .diff_o     (diff_o),
        .borrow_o   (borrow_o)
`ifdef SUB_OVERFLOW_EN
        ,
        .overflow_o (overflow_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: unsigned difference with the borrow taken from a 33-bit wide subtraction.
    function automatic logic [BW:0] ref_sub(input logic [BW-1:0] a, input logic [BW-1:0] b,
                                            input logic bin);
        logic [BW:0] r;
        r = {1'b0, a} - {1'b0, b} - {{BW{1'b0}}, bin};
        return r;
    endfunction

    // Reference: signed overflow means the exact signed result leaves the 32-bit range.
    function automatic logic ref_ovf(input logic [BW-1:0] a, input logic [BW-1:0] b,
                                     input logic bin);
        longint r;
        r = longint'($signed(a)) - longint'($signed(b)) - longint'(bin);
        return (r > 64'sd2147483647) || (r < -64'sd2147483648);
    endfunction

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    // One full transaction: accept, latency check, result check, optional stall, handshake.
    task automatic do_op(input logic [BW-1:0] a, input logic [BW-1:0] b, input logic bin,
                         input int stall);
        logic [BW:0] exp;
        int          lat;
        exp = ref_sub(a, b, bin);
        check("ready_idle", {63'd0, in_ready_o}, 64'd1);
        operand1_i = a;
        operand2_i = b;
        borrow_i   = bin;
        in_valid_i = 1'b1;
        step();
        in_valid_i = 1'b0;
        lat = 0;
        while (!out_valid_o && lat < 20) begin
            check("no_valid_busy_diff", {32'd0, diff_o}, 64'd0);
            step();
            lat++;
        end
        check("latency", 64'(lat), 64'(NC));
        check("diff", {32'd0, diff_o}, {32'd0, exp[BW-1:0]});
        check("borrow", {63'd0, borrow_o}, {63'd0, exp[BW]});
`ifdef SUB_OVERFLOW_EN
        check("overflow", {63'd0, overflow_o}, {63'd0, ref_ovf(a, b, bin)});
`endif
        for (int i = 0; i < stall; i++) begin
            in_valid_i = i[0];
            operand1_i = $urandom;
            operand2_i = $urandom;
            borrow_i   = 1'($urandom);
            step();
            check("stall_valid", {63'd0, out_valid_o}, 64'd1);
            check("stall_ready", {63'd0, in_ready_o}, 64'd0);
            check("stall_diff", {32'd0, diff_o}, {32'd0, exp[BW-1:0]});
            check("stall_borrow", {63'd0, borrow_o}, {63'd0, exp[BW]});
        end
        in_valid_i  = 1'b0;
        out_ready_i = 1'b1;
        step();
        out_ready_i = 1'b0;
        check("post_valid", {63'd0, out_valid_o}, 64'd0);
        check("post_ready", {63'd0, in_ready_o}, 64'd1);
        check("post_diff", {32'd0, diff_o}, 64'd0);
        check("post_borrow", {63'd0, borrow_o}, 64'd0);
    endtask

    initial begin
        logic [BW-1:0] ra;
        logic [BW-1:0] rb;
        #1;
        check("rst_ready", {63'd0, in_ready_o}, 64'd1);
        check("rst_valid", {63'd0, out_valid_o}, 64'd0);
        check("rst_diff", {32'd0, diff_o}, 64'd0);
        check("rst_borrow", {63'd0, borrow_o}, 64'd0);
        step();
        rst_ni = 1'b1;
        step();

        do_op(32'h0000_0005, 32'h0000_0003, 1'b0, 0);
        do_op(32'h0000_0000, 32'h0000_0001, 1'b0, 0);
        do_op(32'h0000_0100, 32'h0000_0001, 1'b1, 0);
        do_op(32'h8000_0000, 32'h0000_0001, 1'b0, 0);
        do_op(32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0, 0);
        do_op(32'h0000_0000, 32'h0000_0000, 1'b1, 1);
        do_op(32'h1234_5678, 32'h1234_5678, 1'b0, 5);

        // Reset while chunk 2 is in flight aborts the operation.
        operand1_i = 32'hDEAD_BEEF;
        operand2_i = 32'h0000_1111;
        in_valid_i = 1'b1;
        step();
        in_valid_i = 1'b0;
        step();
        step();
        rst_ni = 1'b0;
        #1;
        check("midrst_ready", {63'd0, in_ready_o}, 64'd1);
        check("midrst_valid", {63'd0, out_valid_o}, 64'd0);
        check("midrst_diff", {32'd0, diff_o}, 64'd0);
        check("midrst_borrow", {63'd0, borrow_o}, 64'd0);
        step();
        rst_ni = 1'b1;
        step();
        do_op(32'h0000_0010, 32'h0000_0001, 1'b0, 0);

        for (int k = 0; k < 30; k++) begin
            ra = $urandom;
            rb = $urandom;
            if (k % 5 == 1) ra = ra & 32'h0000_00FF;
            if (k % 5 == 2) rb = ra;
            if (k % 5 == 3) ra = ra | 32'h8000_0000;
            do_op(ra, rb, 1'($urandom), int'($urandom_range(0, 3)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
